// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Holds the PC,
//   drives the instruction-memory address, and registers the fetched word
//   together with its PC for the decode/control unit.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall             hold PC and IF/ID this edge
//   pc_src            taken branch: redirect to branch_target, bubble IF/ID
//   branch_target     redirect address (low two bits ignored)
//   imem_addr, if_pc  current PC (combinational)
//   imem_rdata        instruction word read combinationally at imem_addr
//   id_instr, id_pc   registered instruction and its PC
//   id_valid          0 while IF/ID holds a bubble
//   id_opcode, id_funct3, id_funct7b5   slices of id_instr
//
// Optional feature (macro IF_PERF_CNT_EN):
//   perf_stall_cnt    edges with stall=1 and pc_src=0
//   perf_flush_cnt    edges with pc_src=1

module if_id_fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
`ifdef IF_PERF_CNT_EN
  output logic            id_funct7b5,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`else
  output logic            id_funct7b5
`endif
);

  logic [XLEN-1:0] pc_q,    pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] idpc_q,  idpc_d;
  logic            valid_q, valid_d;

  // Priority: flush > stall > advance. imem_rdata is only consumed on advance.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    valid_d = valid_q;
    if (pc_src) begin
      pc_d    = {branch_target[XLEN-1:2], 2'b00};
      instr_d = NOP_INSTR;
      idpc_d  = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_q + XLEN'(4);
      instr_d = imem_rdata;
      idpc_d  = pc_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      idpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = pc_q;
  assign id_instr    = instr_q;
  assign id_pc       = idpc_q;
  assign id_valid    = valid_q;
  assign id_opcode   = instr_q[6:0];
  assign id_funct3   = instr_q[14:12];
  assign id_funct7b5 = instr_q[30];

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_src)
        flush_cnt_q <= flush_cnt_q + 32'd1;
      else if (stall)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: reset, advance, stall, branch flush,
// flush-over-stall, PC wrap and reset during stall (plus perf counters when
// IF_PERF_CNT_EN is defined).

module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, pc_src;
  logic [31:0] branch_target, imem_addr, imem_rdata, if_pc;
  logic [31:0] id_instr, id_pc;
  logic        id_valid, id_funct7b5;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  if_id_fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_pc         (if_pc),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_funct3     (id_funct3),
`ifdef IF_PERF_CNT_EN
    .id_funct7b5   (id_funct7b5),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`else
    .id_funct7b5   (id_funct7b5)
`endif
  );

  // Instruction memory: two fixed words, otherwise an address-tagged word
  // with bit 30 set so funct7b5 is exercised.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'h00A0_0113;
      default: return {1'b0, 1'b1, a[22:0], 7'h33};
    endcase
  endfunction

  always_comb imem_rdata = instr_at(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = '0;
    step(); step();
    check_eq("rst_pc",     imem_addr, 32'h0);
    check_eq("rst_instr",  id_instr,  32'h13);
    check_eq("rst_idpc",   id_pc,     32'h0);
    check_eq("rst_valid",  32'(id_valid), 32'h0);
    check_eq("rst_opcode", 32'(id_opcode), 32'h13);
`ifdef IF_PERF_CNT_EN
    check_eq("rst_pstall", perf_stall_cnt, 32'h0);
    check_eq("rst_pflush", perf_flush_cnt, 32'h0);
`endif
    rst = 1'b0;

    step();
    check_eq("adv1_instr",  id_instr, 32'h0050_0093);
    check_eq("adv1_idpc",   id_pc,    32'h0);
    check_eq("adv1_valid",  32'(id_valid), 32'h1);
    check_eq("adv1_opcode", 32'(id_opcode), 32'h13);
    check_eq("adv1_pc",     imem_addr, 32'h4);
    step();
    check_eq("adv2_idpc",  id_pc,     32'h4);
    check_eq("adv2_instr", id_instr,  32'h00A0_0113);
    check_eq("adv2_pc",    imem_addr, 32'h8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_pc",    imem_addr, 32'h8);
      check_eq("stall_ifpc",  if_pc,     32'h8);
      check_eq("stall_idpc",  id_pc,     32'h4);
      check_eq("stall_instr", id_instr,  32'h00A0_0113);
      check_eq("stall_valid", 32'(id_valid), 32'h1);
    end
    stall = 1'b0;
    step();
    check_eq("unstall_instr", id_instr,  32'h4000_0433);
    check_eq("unstall_idpc",  id_pc,     32'h8);
    check_eq("unstall_pc",    imem_addr, 32'hC);
    step();
    check_eq("pre_br_pc",   imem_addr, 32'h10);
    check_eq("pre_br_idpc", id_pc,     32'hC);

    pc_src = 1'b1; branch_target = 32'h40;
    step();
    pc_src = 1'b0;
    check_eq("br_pc",     imem_addr, 32'h40);
    check_eq("br_instr",  id_instr,  32'h13);
    check_eq("br_valid",  32'(id_valid), 32'h0);
    check_eq("br_idpc",   id_pc,     32'h0);
    step();
    check_eq("br2_idpc",   id_pc,     32'h40);
    check_eq("br2_valid",  32'(id_valid), 32'h1);
    check_eq("br2_instr",  id_instr,  32'h4000_2033);
    check_eq("br2_opcode", 32'(id_opcode), 32'h33);
    check_eq("br2_funct3", 32'(id_funct3), 32'h2);
    check_eq("br2_f7b5",   32'(id_funct7b5), 32'h1);

    pc_src = 1'b1; stall = 1'b1; branch_target = 32'h83;
    step();
    pc_src = 1'b0; stall = 1'b0;
    check_eq("fls_pc",    imem_addr, 32'h80);
    check_eq("fls_instr", id_instr,  32'h13);
    check_eq("fls_valid", 32'(id_valid), 32'h0);
    step();
    check_eq("fls2_idpc", id_pc,     32'h80);
    check_eq("fls2_pc",   imem_addr, 32'h84);
`ifdef IF_PERF_CNT_EN
    check_eq("perf_stall", perf_stall_cnt, 32'd3);
    check_eq("perf_flush", perf_flush_cnt, 32'd2);
`endif

    pc_src = 1'b1; branch_target = 32'hFFFF_FFFE;
    step();
    pc_src = 1'b0;
    check_eq("wrap_br_pc", imem_addr, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_pc",    imem_addr, 32'h0);
    check_eq("wrap_idpc",  id_pc,     32'hFFFF_FFFC);
    check_eq("wrap_valid", 32'(id_valid), 32'h1);
    step();
    check_eq("post_wrap_pc", imem_addr, 32'h4);

    stall = 1'b1;
    step();
    check_eq("pre_rst_stall_pc", imem_addr, 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    check_eq("mid_rst_pc",    imem_addr, 32'h0);
    check_eq("mid_rst_valid", 32'(id_valid), 32'h0);
    check_eq("mid_rst_instr", id_instr,  32'h13);
    check_eq("mid_rst_idpc",  id_pc,     32'h0);
`ifdef IF_PERF_CNT_EN
    check_eq("mid_rst_pstall", perf_stall_cnt, 32'h0);
    check_eq("mid_rst_pflush", perf_flush_cnt, 32'h0);
`endif
    step();
    check_eq("after_rst_instr", id_instr, 32'h0050_0093);
    check_eq("after_rst_valid", 32'(id_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
